// File: rtl/tmds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tmds_pkg                                                                   |
// | Shared TMDS control tokens, alignment states and token-decode helpers.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [9:0] sym);
    return (sym == CTRL_TOKEN_00) || (sym == CTRL_TOKEN_01) ||
           (sym == CTRL_TOKEN_10) || (sym == CTRL_TOKEN_11);
  endfunction

  function automatic logic [1:0] token_code(input logic [9:0] sym);
    logic [1:0] code;
    case (sym)
      CTRL_TOKEN_01: code = 2'b01;
      CTRL_TOKEN_10: code = 2'b10;
      CTRL_TOKEN_11: code = 2'b11;
      default:       code = 2'b00;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tm_unchoice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tm_unchoice                                                                |
// | Inverse of the TMDS transition-minimisation stage: 9-bit q_m to 8-bit data.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tm_unchoice (
  input  logic [8:0] q_m_in,
  output logic [7:0] data_out
);

  assign data_out[0] = q_m_in[0];

  // q_m[8] = 1 marks XOR encoding; 0 marks XNOR, hence the extra inversion.
  for (genvar i = 1; i < 8; i++) begin : g_bit
    assign data_out[i] = (q_m_in[i] ^ q_m_in[i-1]) ^ ~q_m_in[8];
  end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tmds_decoder                                                               |
// | Two-stage TMDS symbol decoder with control-token word-alignment FSM.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_SETTLE   = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       valid_out,
  output logic       locked_out,
  output logic       bitslip_out
);

  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int RUN_W = $clog2(TOKEN_RUN + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);

  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(SEARCH_WINDOW);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TOKEN_RUN);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SLIP_SETTLE);

  logic       s1_valid_q, s1_valid_d;
  logic       s1_token_q, s1_token_d;
  logic [1:0] s1_code_q,  s1_code_d;
  logic [8:0] s1_qm_q,    s1_qm_d;

  logic       valid_q, valid_d;
  logic       de_q,    de_d;
  logic [7:0] data_q,  data_d;
  logic [1:0] ctrl_q,  ctrl_d;

  align_state_e     state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d, run_inc;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d, win_inc;
  logic [SET_W-1:0] settle_q, settle_d, settle_inc;
  logic             locked_q, locked_d;
  logic             bitslip_q, bitslip_d;

  logic [7:0] unchoice_data;

  // Stage 1 keeps the un-inverted word so stage 2 only has to undo the XOR/XNOR chain.
  always_comb begin
    s1_valid_d = valid_in;
    s1_token_d = s1_token_q;
    s1_code_d  = s1_code_q;
    s1_qm_d    = s1_qm_q;
    if (valid_in) begin
      s1_token_d = is_ctrl_token(tmds_in);
      s1_code_d  = token_code(tmds_in);
      s1_qm_d    = {tmds_in[8], tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0]};
    end
  end

  tm_unchoice u_unchoice (
    .q_m_in   (s1_qm_q),
    .data_out (unchoice_data)
  );

  always_comb begin
    valid_d = s1_valid_q;
    de_d    = de_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (s1_valid_q) begin
      if (s1_token_q) begin
        de_d   = 1'b0;
        ctrl_d = s1_code_q;
      end else begin
        de_d   = 1'b1;
        data_d = unchoice_data;
      end
    end
  end

  assign run_inc    = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_W'(1);
  assign win_inc    = (win_cnt_q == WIN_MAX) ? win_cnt_q : win_cnt_q + WIN_W'(1);
  assign settle_inc = (settle_q  == SET_MAX) ? settle_q  : settle_q  + SET_W'(1);

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    win_cnt_d = win_cnt_q;
    settle_d  = settle_q;
    locked_d  = locked_q;
    bitslip_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (s1_valid_q) begin
          run_cnt_d = s1_token_q ? run_inc : '0;
          win_cnt_d = win_inc;
          // A completed token run takes priority over an expiring window.
          if (run_cnt_d == RUN_MAX) begin
            state_d   = LOCKED;
            locked_d  = 1'b1;
            win_cnt_d = '0;
          end else if (win_cnt_d == WIN_MAX) begin
            state_d   = SLIP_WAIT;
            bitslip_d = 1'b1;
            run_cnt_d = '0;
            win_cnt_d = '0;
            settle_d  = '0;
          end
        end
      end
      SLIP_WAIT: begin
        locked_d = 1'b0;
        settle_d = settle_inc;
        if (settle_d == SET_MAX) begin
          state_d   = SEARCH;
          run_cnt_d = '0;
          win_cnt_d = '0;
          settle_d  = '0;
        end
      end
      LOCKED: begin
        if (s1_valid_q) begin
          run_cnt_d = s1_token_q ? run_inc : '0;
          win_cnt_d = (run_cnt_d == RUN_MAX) ? '0 : win_inc;
          if (win_cnt_d == WIN_MAX) begin
            state_d   = SEARCH;
            locked_d  = 1'b0;
            run_cnt_d = '0;
            win_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d   = SEARCH;
        locked_d  = 1'b0;
        run_cnt_d = '0;
        win_cnt_d = '0;
        settle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_token_q <= 1'b0;
      s1_code_q  <= '0;
      s1_qm_q    <= '0;
      valid_q    <= 1'b0;
      de_q       <= 1'b0;
      data_q     <= '0;
      ctrl_q     <= '0;
      state_q    <= SEARCH;
      run_cnt_q  <= '0;
      win_cnt_q  <= '0;
      settle_q   <= '0;
      locked_q   <= 1'b0;
      bitslip_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_token_q <= s1_token_d;
      s1_code_q  <= s1_code_d;
      s1_qm_q    <= s1_qm_d;
      valid_q    <= valid_d;
      de_q       <= de_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      win_cnt_q  <= win_cnt_d;
      settle_q   <= settle_d;
      locked_q   <= locked_d;
      bitslip_q  <= bitslip_d;
    end
  end

  assign data_out    = data_q;
  assign ctrl_out    = ctrl_q;
  assign de_out      = de_q;
  assign valid_out   = valid_q;
  assign locked_out  = locked_q;
  assign bitslip_out = bitslip_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tmds_decoder                                                            |
// | Self-checking bench: reference TMDS encoder, scoreboard, alignment checks. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tmds_decoder;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [9:0] tmds_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       valid_out;
  logic       locked_out;
  logic       bitslip_out;

  always #5 clk_in = ~clk_in;

  tmds_decoder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tmds_in     (tmds_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .ctrl_out    (ctrl_out),
    .de_out      (de_out),
    .valid_out   (valid_out),
    .locked_out  (locked_out),
    .bitslip_out (bitslip_out)
  );

  int total = 0;
  int bad   = 0;
  int slips = 0;
  int disp  = 0;
  logic prev_slip = 1'b0;

  logic [9:0] toks [4];

  typedef struct packed {
    logic       v;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t pipe_q[$];
  logic       m_de   = 1'b0;
  logic [7:0] m_data = '0;
  logic [1:0] m_ctrl = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transition-minimised word of a byte with the chosen chaining operator.
  function automatic logic [7:0] tm_word(input logic [7:0] d, input logic use_xor);
    logic [7:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xor ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
    return q;
  endfunction

  // Full DVI encoder: transition minimisation plus running-disparity DC balance.
  function automatic logic [9:0] encode(input logic [7:0] d);
    int n1, n1q, n0q, b8;
    logic use_xor;
    logic [7:0] qm;
    logic [9:0] q;
    n1      = $countones(d);
    use_xor = !((n1 > 4) || (n1 == 4 && d[0] == 1'b0));
    qm      = tm_word(d, use_xor);
    b8      = use_xor ? 1 : 0;
    n1q     = $countones(qm);
    n0q     = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q    = {~use_xor, use_xor, use_xor ? qm : ~qm};
      disp = use_xor ? disp + n1q - n0q : disp + n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q    = {1'b1, use_xor, ~qm};
      disp = disp + 2 * b8 + n0q - n1q;
    end else begin
      q    = {1'b0, use_xor, qm};
      disp = disp - 2 * (1 - b8) + n1q - n0q;
    end
    return q;
  endfunction

  // Decode an arbitrary symbol by searching for the byte the encoder maps onto it.
  function automatic logic [7:0] search_decode(input logic [9:0] sym);
    logic [7:0] want;
    want = sym[9] ? ~sym[7:0] : sym[7:0];
    for (int b = 0; b < 256; b++) begin
      if (tm_word(8'(b), sym[8]) == want) return 8'(b);
    end
    return 8'h00;
  endfunction

  task automatic cycle(input logic v, input logic [9:0] sym, input logic tok,
                       input logic [7:0] dv, input logic [1:0] cv);
    exp_t e;
    valid_in = v;
    tmds_in  = sym;
    if (v) begin
      if (tok) begin
        m_de   = 1'b0;
        m_ctrl = cv;
      end else begin
        m_de   = 1'b1;
        m_data = dv;
      end
    end
    e.v = v; e.de = m_de; e.data = m_data; e.ctrl = m_ctrl;
    pipe_q.push_back(e);
    @(posedge clk_in); #1;
    if (pipe_q.size() == 2) begin
      e = pipe_q.pop_front();
      chk("valid_out", {31'd0, valid_out}, {31'd0, e.v});
      chk("de_out",    {31'd0, de_out},    {31'd0, e.de});
      chk("data_out",  {24'd0, data_out},  {24'd0, e.data});
      chk("ctrl_out",  {30'd0, ctrl_out},  {30'd0, e.ctrl});
    end
  endtask

  task automatic do_reset(input logic v, input logic [9:0] sym);
    rst_in   = 1'b1;
    valid_in = v;
    tmds_in  = sym;
    @(posedge clk_in); #1;
    chk("rst_valid",   {31'd0, valid_out},   32'd0);
    chk("rst_locked",  {31'd0, locked_out},  32'd0);
    chk("rst_bitslip", {31'd0, bitslip_out}, 32'd0);
    chk("rst_de",      {31'd0, de_out},      32'd0);
    chk("rst_data",    {24'd0, data_out},    32'd0);
    chk("rst_ctrl",    {30'd0, ctrl_out},    32'd0);
    rst_in = 1'b0;
    pipe_q.delete();
    m_de = 1'b0; m_data = '0; m_ctrl = '0;
  endtask

  always @(posedge clk_in) begin
    #1;
    if (bitslip_out) begin
      slips++;
      chk("slip_consecutive", {31'd0, prev_slip}, 32'd0);
      chk("slip_while_locked", {31'd0, locked_out}, 32'd0);
    end
    prev_slip = bitslip_out;
  end

  initial begin
    logic [9:0] sym, rot;
    logic [7:0] b, rot_dec;
    logic       v;
    int idx, slips0, first, second, lock_at;

    toks[0] = 10'b1101010100;
    toks[1] = 10'b0010101011;
    toks[2] = 10'b0101010100;
    toks[3] = 10'b1010101011;

    do_reset(1'b0, 10'd0);
    do_reset(1'b0, 10'd0);

    // Directed symbols with known decodes, then a token run that must lock.
    cycle(1'b1, 10'b0100000000, 1'b0, 8'h00, 2'b00);
    cycle(1'b1, 10'b0011111111, 1'b0, 8'hFF, 2'b00);
    cycle(1'b1, 10'b1011111111, 1'b0, 8'hFE, 2'b00);
    for (int j = 0; j < 8; j++) cycle(1'b1, toks[1], 1'b1, 8'h00, 2'b01);
    chk("lock_early", {31'd0, locked_out}, 32'd0);
    cycle(1'b0, 10'd0, 1'b0, 8'h00, 2'b00);
    chk("lock_rise", {31'd0, locked_out}, 32'd1);
    cycle(1'b0, 10'd0, 1'b0, 8'h00, 2'b00);

    // Every byte through the reference encoder, back-to-back.
    for (int k = 0; k < 256; k++) cycle(1'b1, encode(8'(k)), 1'b0, 8'(k), 2'b00);

    // Random mix of data, tokens and idle cycles.
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        cycle(v, toks[idx], 1'b1, 8'h00, idx[1:0]);
      end else begin
        b   = 8'($urandom_range(0, 255));
        sym = v ? encode(b) : 10'($urandom);
        cycle(v, sym, 1'b0, b, 2'b00);
      end
    end

    // Data-only stream while locked: lock drops after the window, no slip.
    for (int j = 0; j < 8; j++) cycle(1'b1, toks[2], 1'b1, 8'h00, 2'b10);
    cycle(1'b0, 10'd0, 1'b0, 8'h00, 2'b00);
    cycle(1'b0, 10'd0, 1'b0, 8'h00, 2'b00);
    chk("locked_before_drop", {31'd0, locked_out}, 32'd1);
    slips0 = slips;
    for (int m = 1; m <= 2049; m++) begin
      b = 8'($urandom_range(0, 255));
      cycle(1'b1, encode(b), 1'b0, b, 2'b00);
      if (m == 2048) chk("locked_at_2047", {31'd0, locked_out}, 32'd1);
      if (m == 2049) chk("locked_dropped", {31'd0, locked_out}, 32'd0);
    end
    chk("no_slip_on_drop", 32'(slips - slips0), 32'd0);

    // Relock, then reset in the middle of a valid stream.
    for (int j = 0; j < 8; j++) cycle(1'b1, toks[3], 1'b1, 8'h00, 2'b11);
    for (int j = 0; j < 3; j++) cycle(1'b1, encode(8'h5A), 1'b0, 8'h5A, 2'b00);
    chk("locked_before_reset", {31'd0, locked_out}, 32'd1);
    do_reset(1'b1, encode(8'hA5));

    // Misaligned tokens: slips every window plus settle, then realign.
    rot     = {toks[1][2:0], toks[1][9:3]};
    rot_dec = search_decode(rot);
    first   = -1;
    second  = -1;
    for (int m = 1; m <= 5000 && second < 0; m++) begin
      cycle(1'b1, rot, 1'b0, rot_dec, 2'b00);
      if (bitslip_out) begin
        if (first < 0) first = m;
        else second = m;
      end
    end
    chk("slip_first_step", 32'(first), 32'd2049);
    chk("slip_spacing", 32'(second - first), 32'd2064);
    lock_at = -1;
    for (int m = 1; m <= 200 && lock_at < 0; m++) begin
      cycle(1'b1, toks[0], 1'b1, 8'h00, 2'b00);
      if (locked_out) lock_at = m;
    end
    chk("relock_steps", 32'(lock_at), 32'd24);
    cycle(1'b0, 10'd0, 1'b0, 8'h00, 2'b00);
    cycle(1'b0, 10'd0, 1'b0, 8'h00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
